// File: rtl/frog_grid_if.sv
// Frog controller bundle: frame/button/hazard/raster inputs
// and sprite position, pixel flag and game status outputs.
interface frog_grid_if;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       hit;
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic       in_frog;
  logic [1:0] lives;
  logic [7:0] score;
  logic       game_over;
  logic       busy;

  modport slave (
    input  frame_tick, btn_up, btn_down,
    input  btn_left, btn_right, hit,
    input  h_counter, v_counter,
    output frog_x, frog_y, in_frog,
    output lives, score, game_over, busy
  );

  modport master (
    output frame_tick, btn_up, btn_down,
    output btn_left, btn_right, hit,
    output h_counter, v_counter,
    input  frog_x, frog_y, in_frog,
    input  lives, score, game_over, busy
  );
endinterface

// File: rtl/frog_grid_controller.sv
// Grid-stepped frog player: hops, collisions, lives, score
// and a registered sprite pixel flag for the colour mux.
module frog_grid_controller #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int CELL           = 32,
  parameter int FROG_SIZE      = 32,
  parameter int START_COL      = 9,
  parameter int START_ROW      = 14,
  parameter int LIVES          = 3,
  parameter int HOP_FRAMES     = 8,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  frog_grid_if.slave   io
);

  localparam int COLS = H_ACTIVE / CELL;
  localparam int ROWS = V_ACTIVE / CELL;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int OFF  = (CELL - FROG_SIZE) / 2;
  localparam int FMAX = (HOP_FRAMES > RESPAWN_FRAMES) ?
                        HOP_FRAMES : RESPAWN_FRAMES;
  // at least 3 bits so the blink tap (bit 2) always exists
  localparam int FW   = ($clog2(FMAX + 1) < 3) ?
                        3 : $clog2(FMAX + 1);

  typedef enum logic [1:0] {
    IDLE, HOP, DEAD, OVER
  } state_t;

  state_t         state;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [FW-1:0]  fcnt;
  logic [1:0]     lives;
  logic [7:0]     score;
  logic           game_over;
  logic           busy;
  logic           in_frog;
  logic [3:0]     btn_q;
  logic           pend_v;
  logic [1:0]     pend_d;
  logic           over_req;

  logic [3:0]     btn;
  logic [3:0]     press;
  logic [1:0]     press_d;
  logic           move_ok;
  logic [CW-1:0]  ncol;
  logic [RW-1:0]  nrow;
  logic [9:0]     fx;
  logic [9:0]     fy;
  logic           pix_in;
  logic           pix_show;

  assign btn = {io.btn_right, io.btn_left,
                io.btn_down, io.btn_up};
  assign press = btn & ~btn_q;

  always_comb begin
    press_d = 2'd3;
    priority case (1'b1)
      press[0]: press_d = 2'd0;
      press[1]: press_d = 2'd1;
      press[2]: press_d = 2'd2;
      default:  press_d = 2'd3;
    endcase
  end

  always_comb begin
    ncol    = col;
    nrow    = row;
    move_ok = 1'b0;
    unique case (pend_d)
      2'd0: begin
        move_ok = (row != '0);
        nrow    = row - RW'(1);
      end
      2'd1: begin
        move_ok = (row != RW'(ROWS - 1));
        nrow    = row + RW'(1);
      end
      2'd2: begin
        move_ok = (col != '0);
        ncol    = col - CW'(1);
      end
      default: begin
        move_ok = (col != CW'(COLS - 1));
        ncol    = col + CW'(1);
      end
    endcase
  end

  assign fx = 10'(col) * 10'(CELL) + 10'(OFF);
  assign fy = 10'(row) * 10'(CELL) + 10'(OFF);

  assign pix_in =
    (io.h_counter >= fx) &&
    (io.h_counter <  fx + 10'(FROG_SIZE)) &&
    (io.v_counter >= fy) &&
    (io.v_counter <  fy + 10'(FROG_SIZE)) &&
    (io.h_counter <  10'(H_ACTIVE)) &&
    (io.v_counter <  10'(V_ACTIVE));

  assign pix_show = (state != OVER) &&
                    ((state != DEAD) || fcnt[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= CW'(START_COL);
      row       <= RW'(START_ROW);
      fcnt      <= '0;
      lives     <= 2'(LIVES);
      score     <= '0;
      game_over <= 1'b0;
      busy      <= 1'b0;
      in_frog   <= 1'b0;
      btn_q     <= '0;
      pend_v    <= 1'b0;
      pend_d    <= '0;
      over_req  <= 1'b0;
    end else begin
      btn_q   <= btn;
      in_frog <= pix_in && pix_show;

      if (io.frame_tick) begin
        pend_v <= 1'b0;
      end else if (|press) begin
        pend_v <= 1'b1;
        pend_d <= press_d;
      end

      if ((state == OVER) && (|press))
        over_req <= 1'b1;

      if (io.frame_tick) begin
        unique case (state)
          IDLE, HOP: begin
            if (io.hit) begin
              lives <= lives - 2'd1;
              col   <= CW'(START_COL);
              row   <= RW'(START_ROW);
              fcnt  <= '0;
              state <= DEAD;
              busy  <= 1'b1;
            end else if (state == IDLE) begin
              if (pend_v && move_ok) begin
                col   <= ncol;
                row   <= nrow;
                fcnt  <= '0;
                state <= HOP;
                busy  <= 1'b1;
              end
            end else if (fcnt == FW'(HOP_FRAMES - 1)) begin
              // landing on the home row scores and respawns
              if (row == '0) begin
                if (score != 8'hFF)
                  score <= score + 8'd1;
                col <= CW'(START_COL);
                row <= RW'(START_ROW);
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              fcnt <= fcnt + FW'(1);
            end
          end
          DEAD: begin
            if (fcnt == FW'(RESPAWN_FRAMES - 1)) begin
              busy <= 1'b0;
              if (lives == 2'd0) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              fcnt <= fcnt + FW'(1);
            end
          end
          default: begin
            if (over_req) begin
              lives     <= 2'(LIVES);
              score     <= '0;
              col       <= CW'(START_COL);
              row       <= RW'(START_ROW);
              state     <= IDLE;
              game_over <= 1'b0;
              over_req  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign io.frog_x    = fx;
  assign io.frog_y    = fy;
  assign io.in_frog   = in_frog;
  assign io.lives     = lives;
  assign io.score     = score;
  assign io.game_over = game_over;
  assign io.busy      = busy;

endmodule
